// File: rtl/wvb_hdr_pkg.sv
// ---------------------------------------------------------------------------
// wvb_hdr_pkg
// Shared definitions for the waveform-buffer header serializer:
//   - fixed flag-field widths of the header bundle
//   - bit-offset helpers for every bundle field, given the generic widths
//   - derived widths: HDR_WIDTH and NWORDS
//   - FSM state type and state encodings
// Bundle layout, LSB first:
//   evt_ltc, start_addr, stop_addr, trig_src, cnst_run, pre_conf, sync_rdy,
//   bsum, bsum_len_sel, bsum_valid
// ---------------------------------------------------------------------------
package wvb_hdr_pkg;

  localparam int TRIG_SRC_W     = 2;
  localparam int CNST_RUN_W     = 1;
  localparam int PRE_CONF_W     = 5;
  localparam int SYNC_RDY_W     = 1;
  localparam int BSUM_LEN_SEL_W = 3;
  localparam int BSUM_VALID_W   = 1;

  // Sum of all fixed-width flag fields (13).
  localparam int FLAGS_W = TRIG_SRC_W + CNST_RUN_W + PRE_CONF_W + SYNC_RDY_W +
                           BSUM_LEN_SEL_W + BSUM_VALID_W;

  localparam int HDR_COUNT_W = 16;

  typedef logic [0:0] state_t;
  localparam state_t IDLE = 1'b0;
  localparam state_t SEND = 1'b1;

  function automatic int hdr_width(input int ltc_w, input int addr_w, input int bsum_w);
    return ltc_w + 2 * addr_w + bsum_w + FLAGS_W;
  endfunction

  function automatic int off_start_addr(input int ltc_w);
    return ltc_w;
  endfunction

  function automatic int off_stop_addr(input int ltc_w, input int addr_w);
    return ltc_w + addr_w;
  endfunction

  function automatic int off_trig_src(input int ltc_w, input int addr_w);
    return ltc_w + 2 * addr_w;
  endfunction

  function automatic int off_cnst_run(input int ltc_w, input int addr_w);
    return off_trig_src(ltc_w, addr_w) + TRIG_SRC_W;
  endfunction

  function automatic int off_pre_conf(input int ltc_w, input int addr_w);
    return off_cnst_run(ltc_w, addr_w) + CNST_RUN_W;
  endfunction

  function automatic int off_sync_rdy(input int ltc_w, input int addr_w);
    return off_pre_conf(ltc_w, addr_w) + PRE_CONF_W;
  endfunction

  function automatic int off_bsum(input int ltc_w, input int addr_w);
    return off_sync_rdy(ltc_w, addr_w) + SYNC_RDY_W;
  endfunction

  function automatic int off_bsum_len_sel(input int ltc_w, input int addr_w, input int bsum_w);
    return off_bsum(ltc_w, addr_w) + bsum_w;
  endfunction

  function automatic int off_bsum_valid(input int ltc_w, input int addr_w, input int bsum_w);
    return off_bsum_len_sel(ltc_w, addr_w, bsum_w) + BSUM_LEN_SEL_W;
  endfunction

  // Payload is {pad, wfm_len[addr_w:0], bundle}; round up to whole words.
  function automatic int nwords(input int hdr_w, input int addr_w, input int word_w);
    return (hdr_w + addr_w + 1 + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/wvb_hdr_serializer_if.sv
// ---------------------------------------------------------------------------
// wvb_hdr_serializer_if
// Bundles the header-FIFO side and the word-stream side of the serializer.
//   hdr_bundle / hdr_valid / hdr_ready : header FIFO handshake
//   dout / dout_valid / dout_ready / dout_last : record word stream
//   busy, hdr_count : status
// Modports:
//   slave  - the serializer
//   master - the environment (FIFO + arbiter, or a testbench)
// ---------------------------------------------------------------------------
interface wvb_hdr_serializer_if
  import wvb_hdr_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int LTC_WIDTH  = 49,
  parameter int BSUM_WIDTH = 19,
  parameter int WORD_WIDTH = 16
);

  localparam int HDR_WIDTH = hdr_width(LTC_WIDTH, ADDR_WIDTH, BSUM_WIDTH);

  logic [HDR_WIDTH-1:0]   hdr_bundle;
  logic                   hdr_valid;
  logic                   hdr_ready;
  logic [WORD_WIDTH-1:0]  dout;
  logic                   dout_valid;
  logic                   dout_ready;
  logic                   dout_last;
  logic                   busy;
  logic [HDR_COUNT_W-1:0] hdr_count;

  modport slave (
    input  hdr_bundle, hdr_valid, dout_ready,
    output hdr_ready, dout, dout_valid, dout_last, busy, hdr_count
  );

  modport master (
    output hdr_bundle, hdr_valid, dout_ready,
    input  hdr_ready, dout, dout_valid, dout_last, busy, hdr_count
  );

endinterface

// File: rtl/wvb_hdr_field_split.sv
// ---------------------------------------------------------------------------
// wvb_hdr_field_split
// Purely combinational splitter of a header bundle into its fields.
// Ports:
//   hdr_bundle   in  HDR_WIDTH   packed header bundle
//   evt_ltc      out LTC_WIDTH   event local time counter
//   start_addr   out ADDR_WIDTH  waveform start address
//   stop_addr    out ADDR_WIDTH  waveform stop address
//   trig_src     out 2           trigger source
//   cnst_run     out 1           constant-run flag
//   pre_conf     out 5           pre-trigger configuration
//   sync_rdy     out 1           sync ready flag
//   bsum         out BSUM_WIDTH  baseline sum
//   bsum_len_sel out 3           baseline sum length select
//   bsum_valid   out 1           baseline sum valid
// ---------------------------------------------------------------------------
module wvb_hdr_field_split
  import wvb_hdr_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int LTC_WIDTH  = 49,
  parameter int BSUM_WIDTH = 19,
  localparam int HDR_WIDTH = hdr_width(LTC_WIDTH, ADDR_WIDTH, BSUM_WIDTH)
) (
  input  logic [HDR_WIDTH-1:0]      hdr_bundle,
  output logic [LTC_WIDTH-1:0]      evt_ltc,
  output logic [ADDR_WIDTH-1:0]     start_addr,
  output logic [ADDR_WIDTH-1:0]     stop_addr,
  output logic [TRIG_SRC_W-1:0]     trig_src,
  output logic                      cnst_run,
  output logic [PRE_CONF_W-1:0]     pre_conf,
  output logic                      sync_rdy,
  output logic [BSUM_WIDTH-1:0]     bsum,
  output logic [BSUM_LEN_SEL_W-1:0] bsum_len_sel,
  output logic                      bsum_valid
);

  localparam int O_START = off_start_addr(LTC_WIDTH);
  localparam int O_STOP  = off_stop_addr(LTC_WIDTH, ADDR_WIDTH);
  localparam int O_TRIG  = off_trig_src(LTC_WIDTH, ADDR_WIDTH);
  localparam int O_CNST  = off_cnst_run(LTC_WIDTH, ADDR_WIDTH);
  localparam int O_PRE   = off_pre_conf(LTC_WIDTH, ADDR_WIDTH);
  localparam int O_SYNC  = off_sync_rdy(LTC_WIDTH, ADDR_WIDTH);
  localparam int O_BSUM  = off_bsum(LTC_WIDTH, ADDR_WIDTH);
  localparam int O_BSEL  = off_bsum_len_sel(LTC_WIDTH, ADDR_WIDTH, BSUM_WIDTH);
  localparam int O_BVLD  = off_bsum_valid(LTC_WIDTH, ADDR_WIDTH, BSUM_WIDTH);

  assign evt_ltc      = hdr_bundle[0 +: LTC_WIDTH];
  assign start_addr   = hdr_bundle[O_START +: ADDR_WIDTH];
  assign stop_addr    = hdr_bundle[O_STOP +: ADDR_WIDTH];
  assign trig_src     = hdr_bundle[O_TRIG +: TRIG_SRC_W];
  assign cnst_run     = hdr_bundle[O_CNST];
  assign pre_conf     = hdr_bundle[O_PRE +: PRE_CONF_W];
  assign sync_rdy     = hdr_bundle[O_SYNC];
  assign bsum         = hdr_bundle[O_BSUM +: BSUM_WIDTH];
  assign bsum_len_sel = hdr_bundle[O_BSEL +: BSUM_LEN_SEL_W];
  assign bsum_valid   = hdr_bundle[O_BVLD];

endmodule

// File: rtl/wvb_hdr_serializer.sv
// ---------------------------------------------------------------------------
// wvb_hdr_serializer
// Pops one header bundle from the per-channel header FIFO, appends the
// derived waveform length and streams the record {pad, wfm_len, bundle} as
// WORD_WIDTH-bit words, LSB word first, towards the readout arbiter.
// Ports:
//   clk  in  system clock
//   rst  in  synchronous active-high reset (aborts a record in flight)
//   bus  slave modport of wvb_hdr_serializer_if:
//        hdr_bundle/hdr_valid/hdr_ready  header input handshake
//        dout/dout_valid/dout_ready      word output handshake
//        dout_last                       final word of the record
//        busy                            record in progress
//        hdr_count                       completed records (wraps)
// Build option:
//   WVB_HDR_SER_CHK_EN  when defined, one extra word equal to the XOR of all
//                       payload words follows the payload and carries
//                       dout_last.
// ---------------------------------------------------------------------------
module wvb_hdr_serializer
  import wvb_hdr_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int LTC_WIDTH  = 49,
  parameter int BSUM_WIDTH = 19,
  parameter int WORD_WIDTH = 16
) (
  input logic                clk,
  input logic                rst,
  wvb_hdr_serializer_if.slave bus
);

  localparam int HDR_WIDTH = hdr_width(LTC_WIDTH, ADDR_WIDTH, BSUM_WIDTH);
  localparam int LEN_W     = ADDR_WIDTH + 1;
  localparam int NWORDS    = nwords(HDR_WIDTH, ADDR_WIDTH, WORD_WIDTH);
  localparam int PAY_W     = NWORDS * WORD_WIDTH;
`ifdef WVB_HDR_SER_CHK_EN
  localparam int NSEND     = NWORDS + 1;
`else
  localparam int NSEND     = NWORDS;
`endif
  localparam int IDX_W     = (NSEND > 1) ? $clog2(NSEND) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSEND - 1);

  // Field extraction
  logic [LTC_WIDTH-1:0]      evt_ltc;
  logic [ADDR_WIDTH-1:0]     start_addr;
  logic [ADDR_WIDTH-1:0]     stop_addr;
  logic [TRIG_SRC_W-1:0]     trig_src;
  logic                      cnst_run;
  logic [PRE_CONF_W-1:0]     pre_conf;
  logic                      sync_rdy;
  logic [BSUM_WIDTH-1:0]     bsum;
  logic [BSUM_LEN_SEL_W-1:0] bsum_len_sel;
  logic                      bsum_valid;

  wvb_hdr_field_split #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LTC_WIDTH  (LTC_WIDTH),
    .BSUM_WIDTH (BSUM_WIDTH)
  ) u_split (
    .hdr_bundle   (bus.hdr_bundle),
    .evt_ltc      (evt_ltc),
    .start_addr   (start_addr),
    .stop_addr    (stop_addr),
    .trig_src     (trig_src),
    .cnst_run     (cnst_run),
    .pre_conf     (pre_conf),
    .sync_rdy     (sync_rdy),
    .bsum         (bsum),
    .bsum_len_sel (bsum_len_sel),
    .bsum_valid   (bsum_valid)
  );

  // Only the addresses matter here; the rest travels inside the raw bundle.
  logic unused_fields;
  assign unused_fields = ^{evt_ltc, trig_src, cnst_run, pre_conf, sync_rdy,
                           bsum, bsum_len_sel, bsum_valid};

  // Waveform length: the buffer is circular, so the span is taken modulo
  // the depth and a stop just below start gives the full depth.
  logic [ADDR_WIDTH-1:0] addr_span;
  logic [LEN_W-1:0]      wfm_len;

  always_comb begin
    addr_span = stop_addr - start_addr;
    wfm_len   = {1'b0, addr_span} + LEN_W'(1);
  end

  // State
  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [HDR_COUNT_W-1:0] hdr_count_q, hdr_count_d;
  logic [PAY_W-1:0]       payload_q, payload_d;

  logic hdr_ready_c;
  logic hdr_accept;
  logic word_xfer;
  logic last_word;

  always_comb begin
    // hdr_ready is held low while rst is high so nothing is popped from the
    // FIFO in a cycle whose effect reset would discard.
    hdr_ready_c = (state_q == IDLE) && !rst;
    hdr_accept  = hdr_ready_c && bus.hdr_valid;
    word_xfer   = (state_q == SEND) && bus.dout_ready;
    last_word   = (idx_q == LAST_IDX);

    state_d     = state_q;
    idx_d       = idx_q;
    hdr_count_d = hdr_count_q;
    payload_d   = payload_q;

    if (hdr_accept) begin
      state_d   = SEND;
      idx_d     = '0;
      payload_d = PAY_W'({wfm_len, bus.hdr_bundle});
    end else if (word_xfer) begin
      if (last_word) begin
        // Returning to IDLE forces at least one idle cycle between records.
        state_d     = IDLE;
        idx_d       = '0;
        hdr_count_d = hdr_count_q + HDR_COUNT_W'(1);
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      hdr_count_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      hdr_count_q <= hdr_count_d;
    end
  end

  // Record register is data only; it is meaningless outside SEND.
  always_ff @(posedge clk) begin
    payload_q <= payload_d;
  end

  // Word selection
  logic [NSEND-1:0][WORD_WIDTH-1:0] words;
`ifdef WVB_HDR_SER_CHK_EN
  logic [WORD_WIDTH-1:0] chk_word;
`endif

  always_comb begin
    words = '0;
    for (int k = 0; k < NWORDS; k++) begin
      words[k] = payload_q[k*WORD_WIDTH +: WORD_WIDTH];
    end
`ifdef WVB_HDR_SER_CHK_EN
    chk_word = '0;
    for (int k = 0; k < NWORDS; k++) begin
      chk_word = chk_word ^ payload_q[k*WORD_WIDTH +: WORD_WIDTH];
    end
    words[NWORDS] = chk_word;
`endif
  end

  // dout is a pure function of registered state, so it is stable for as long
  // as the index is held by a stalled dout_ready.
  assign bus.hdr_ready  = hdr_ready_c;
  assign bus.busy       = (state_q == SEND);
  assign bus.dout_valid = (state_q == SEND);
  assign bus.dout_last  = (state_q == SEND) && last_word;
  assign bus.dout       = (state_q == SEND) ? words[idx_q] : '0;
  assign bus.hdr_count  = hdr_count_q;

endmodule

// File: tb/tb_wvb_hdr_serializer.sv
module tb_wvb_hdr_serializer;

`ifdef WVB_HDR_SER_CHK_EN
  localparam int NREC = 9;
`else
  localparam int NREC = 8;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wvb_hdr_serializer_if bus ();

  wvb_hdr_serializer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [15:0] got      [16];
  logic        got_last [16];
  int          got_n;
  int          stab_err;
  bit          rec_timeout;

  // Bundle builder at default widths, explicit bit positions.
  function automatic logic [102:0] mk_hdr(
    input logic [48:0] ltc, input logic [10:0] start, input logic [10:0] stop,
    input logic [1:0] trig, input logic cnst, input logic [4:0] pre,
    input logic sync, input logic [18:0] bsum, input logic [2:0] sel,
    input logic bv);
    logic [102:0] h;
    h = '0;
    h[48:0]   = ltc;
    h[59:49]  = start;
    h[70:60]  = stop;
    h[72:71]  = trig;
    h[73]     = cnst;
    h[78:74]  = pre;
    h[79]     = sync;
    h[98:80]  = bsum;
    h[101:99] = sel;
    h[102]    = bv;
    return h;
  endfunction

  // Expected record word k (k == 8 is the checksum word).
  function automatic logic [15:0] exp_word(input logic [102:0] h, input int k);
    logic [127:0] p;
    logic [10:0]  d;
    logic [11:0]  len;
    logic [15:0]  c;
    d   = h[70:60] - h[59:49];
    len = {1'b0, d} + 12'd1;
    p   = '0;
    p[102:0]   = h;
    p[114:103] = len;
    if (k < 8) return p[k*16 +: 16];
    c = '0;
    for (int i = 0; i < 8; i++) c = c ^ p[i*16 +: 16];
    return c;
  endfunction

  task automatic send_hdr(input logic [102:0] h, output bit ok);
    int t;
    t = 0;
    @(negedge clk);
    bus.hdr_bundle = h;
    bus.hdr_valid  = 1'b1;
    while (!bus.hdr_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    ok = bus.hdr_ready;
    @(posedge clk);
    #1;
    bus.hdr_valid  = 1'b0;
    bus.hdr_bundle = ~h;
  endtask

  // mode 0: always ready, 1: 1010..., 2: random stalls
  task automatic collect(input int mode);
    bit          done;
    int          cyc;
    bit          prev_stall;
    logic [15:0] prev_d;
    logic        prev_l;
    got_n = 0; stab_err = 0; done = 0; cyc = 0;
    prev_stall = 0; prev_d = '0; prev_l = 1'b0;
    while (!done && cyc < 300) begin
      @(negedge clk);
      case (mode)
        0:       bus.dout_ready = 1'b1;
        1:       bus.dout_ready = (cyc % 2 == 0);
        default: bus.dout_ready = ($urandom_range(0, 2) != 0);
      endcase
      if (bus.dout_valid) begin
        if (prev_stall && (bus.dout !== prev_d || bus.dout_last !== prev_l)) stab_err++;
        if (bus.dout_ready) begin
          if (got_n < 16) begin
            got[got_n]      = bus.dout;
            got_last[got_n] = bus.dout_last;
          end
          got_n++;
          if (bus.dout_last || got_n >= 16) done = 1;
        end
        prev_stall = !bus.dout_ready;
        prev_d     = bus.dout;
        prev_l     = bus.dout_last;
      end else begin
        prev_stall = 0;
      end
      cyc++;
    end
    rec_timeout    = !done;
    bus.dout_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.hdr_valid  = 1'b0;
    bus.hdr_bundle = '0;
    bus.dout_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_assert++; if (bus.hdr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_hdr_ready got=%b exp=0", bus.hdr_ready); end
    n_assert++; if (bus.dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dout_valid got=%b exp=0", bus.dout_valid); end
    n_assert++; if (bus.dout !== 16'h0) begin n_fail++; $display("FAIL reset_dout got=%h exp=0000", bus.dout); end
    n_assert++; if (bus.dout_last !== 1'b0) begin n_fail++; $display("FAIL reset_dout_last got=%b exp=0", bus.dout_last); end
    n_assert++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    n_assert++; if (bus.hdr_count !== 16'h0) begin n_fail++; $display("FAIL reset_hdr_count got=%h exp=0000", bus.hdr_count); end
    rst = 1'b0;
    @(negedge clk);
    n_assert++; if (bus.hdr_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_hdr_ready got=%b exp=1", bus.hdr_ready); end
  endtask

  task automatic test_basic();
    logic [102:0] h;
    logic [15:0]  hw [8];
    logic [15:0]  c;
    logic [11:0]  len;
    bit           ok;
    hw[0] = 16'h9ABC; hw[1] = 16'h5678; hw[2] = 16'h1234; hw[3] = 16'hF200;
    hw[4] = 16'h001F; hw[5] = 16'h0000; hw[6] = 16'h8000; hw[7] = 16'h0000;
    h = mk_hdr(49'h0_1234_5678_9ABC, 11'h100, 11'h1FF, 2'd0, 1'b0, 5'd0, 1'b0, 19'd0, 3'd0, 1'b0);
    bus.dout_ready = 1'b0;
    send_hdr(h, ok);
    n_assert++; if (!ok) begin n_fail++; $display("FAIL basic_accept got=0 exp=1"); end
    @(negedge clk);
    n_assert++; if (bus.dout_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency_valid got=%b exp=1", bus.dout_valid); end
    n_assert++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got=%b exp=1", bus.busy); end
    n_assert++; if (bus.hdr_ready !== 1'b0) begin n_fail++; $display("FAIL basic_hdr_ready_send got=%b exp=0", bus.hdr_ready); end
    n_assert++; if (bus.dout !== 16'h9ABC) begin n_fail++; $display("FAIL basic_first_word got=%h exp=9abc", bus.dout); end
    collect(0);
    n_assert++; if (rec_timeout || got_n != NREC) begin n_fail++; $display("FAIL basic_word_count got=%0d exp=%0d", got_n, NREC); end
    c = '0;
    for (int k = 0; k < 8; k++) begin
      c = c ^ hw[k];
      n_assert++; if (got[k] !== hw[k]) begin n_fail++; $display("FAIL basic_word%0d got=%h exp=%h", k, got[k], hw[k]); end
    end
    for (int k = 0; k < NREC; k++) begin
      n_assert++; if (got_last[k] !== (k == NREC - 1)) begin n_fail++; $display("FAIL basic_last%0d got=%b exp=%b", k, got_last[k], (k == NREC - 1)); end
    end
`ifdef WVB_HDR_SER_CHK_EN
    n_assert++; if (got[8] !== c) begin n_fail++; $display("FAIL basic_checksum got=%h exp=%h", got[8], c); end
`endif
    len = {got[7][2:0], got[6][15:7]};
    n_assert++; if (len !== 12'h100) begin n_fail++; $display("FAIL basic_wfm_len got=%h exp=100", len); end
    @(negedge clk);
    n_assert++; if (bus.hdr_count !== 16'd1) begin n_fail++; $display("FAIL basic_hdr_count got=%0d exp=1", bus.hdr_count); end
    n_assert++; if (bus.dout_valid !== 1'b0) begin n_fail++; $display("FAIL basic_idle_valid got=%b exp=0", bus.dout_valid); end
  endtask

  task automatic test_wrap();
    logic [102:0] h;
    logic [11:0]  len;
    logic [11:0]  exp_len [2];
    logic [10:0]  st [2];
    logic [10:0]  sp [2];
    bit           ok;
    st[0] = 11'h010; sp[0] = 11'h00F; exp_len[0] = 12'h800;
    st[1] = 11'h3A5; sp[1] = 11'h3A5; exp_len[1] = 12'h001;
    for (int t = 0; t < 2; t++) begin
      h = mk_hdr(49'h1_0000_0000_0001, st[t], sp[t], 2'd1, 1'b1, 5'h0A, 1'b0, 19'h7FFFF, 3'd2, 1'b1);
      send_hdr(h, ok);
      collect(0);
      n_assert++; if (!ok || rec_timeout || got_n != NREC) begin n_fail++; $display("FAIL wrap%0d_count got=%0d exp=%0d", t, got_n, NREC); end
      len = {got[7][2:0], got[6][15:7]};
      n_assert++; if (len !== exp_len[t]) begin n_fail++; $display("FAIL wrap%0d_wfm_len got=%h exp=%h", t, len, exp_len[t]); end
      for (int k = 0; k < NREC; k++) begin
        n_assert++; if (got[k] !== exp_word(h, k)) begin n_fail++; $display("FAIL wrap%0d_word%0d got=%h exp=%h", t, k, got[k], exp_word(h, k)); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [102:0] h;
    bit           ok;
    h = mk_hdr(49'h1_5A5A_C3C3_0F0F, 11'h7F0, 11'h00F, 2'b10, 1'b1, 5'h15, 1'b1, 19'h5ABCD, 3'b101, 1'b1);
    for (int m = 0; m < 3; m++) begin
      send_hdr(h, ok);
      collect(m);
      n_assert++; if (!ok || rec_timeout || got_n != NREC) begin n_fail++; $display("FAIL bp_mode%0d_count got=%0d exp=%0d", m, got_n, NREC); end
      n_assert++; if (stab_err != 0) begin n_fail++; $display("FAIL bp_mode%0d_stable got=%0d changes exp=0", m, stab_err); end
      for (int k = 0; k < NREC; k++) begin
        n_assert++; if (got[k] !== exp_word(h, k)) begin n_fail++; $display("FAIL bp_mode%0d_word%0d got=%h exp=%h", m, k, got[k], exp_word(h, k)); end
        n_assert++; if (got_last[k] !== (k == NREC - 1)) begin n_fail++; $display("FAIL bp_mode%0d_last%0d got=%b", m, k, got_last[k]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [102:0] b [3];
    logic [15:0]  rw [32];
    logic         rl [32];
    int           i, n, idle, cyc;
    bit           acc;
    b[0] = mk_hdr(49'h0_0000_0000_1111, 11'h000, 11'h7FF, 2'd3, 1'b0, 5'h01, 1'b1, 19'h00001, 3'd7, 1'b0);
    b[1] = mk_hdr(49'h1_FFFF_FFFF_FFFF, 11'h200, 11'h1FF, 2'd0, 1'b1, 5'h1F, 1'b0, 19'h40000, 3'd0, 1'b1);
    b[2] = mk_hdr(49'h0_ABCD_EF01_2345, 11'h055, 11'h0AA, 2'd2, 1'b0, 5'h10, 1'b1, 19'h12345, 3'd4, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    i = 0; n = 0; idle = 0; cyc = 0; acc = 0;
    bus.dout_ready = 1'b1;
    while (n < 3 * NREC && cyc < 200) begin
      @(negedge clk);
      if (acc) i++;
      if (i < 3) begin
        bus.hdr_valid  = 1'b1;
        bus.hdr_bundle = b[i];
      end else begin
        bus.hdr_valid = 1'b0;
      end
      acc = bus.hdr_valid && bus.hdr_ready;
      if (bus.dout_valid) begin
        rw[n] = bus.dout;
        rl[n] = bus.dout_last;
        n++;
      end else if (n > 0) begin
        idle++;
      end
      cyc++;
    end
    bus.hdr_valid = 1'b0;
    n_assert++; if (n != 3 * NREC) begin n_fail++; $display("FAIL b2b_words got=%0d exp=%0d", n, 3 * NREC); end
    n_assert++; if (idle != 2) begin n_fail++; $display("FAIL b2b_idle_cycles got=%0d exp=2", idle); end
    for (int k = 0; k < n; k++) begin
      n_assert++; if (rw[k] !== exp_word(b[k / NREC], k % NREC)) begin n_fail++; $display("FAIL b2b_word%0d got=%h exp=%h", k, rw[k], exp_word(b[k / NREC], k % NREC)); end
      n_assert++; if (rl[k] !== ((k % NREC) == NREC - 1)) begin n_fail++; $display("FAIL b2b_last%0d got=%b", k, rl[k]); end
    end
    @(negedge clk);
    n_assert++; if (bus.hdr_count !== 16'd3) begin n_fail++; $display("FAIL b2b_hdr_count got=%0d exp=3", bus.hdr_count); end
  endtask

  task automatic test_count_wrap();
    logic [102:0] h;
    bit           ok;
    @(negedge clk);
    force dut.hdr_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.hdr_count_q;
    @(negedge clk);
    n_assert++; if (bus.hdr_count !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload got=%h exp=ffff", bus.hdr_count); end
    h = mk_hdr(49'h0_0000_DEAD_BEEF, 11'h001, 11'h002, 2'd1, 1'b0, 5'h03, 1'b0, 19'h00100, 3'd1, 1'b0);
    send_hdr(h, ok);
    collect(0);
    @(negedge clk);
    n_assert++; if (!ok || rec_timeout || bus.hdr_count !== 16'h0000) begin n_fail++; $display("FAIL wrap_hdr_count got=%h exp=0000", bus.hdr_count); end
  endtask

  task automatic test_reset_abort();
    logic [102:0]     h, h2;
    logic [15:0]      cnt;
    int               k, cyc;
    bit               ok;
    h  = mk_hdr(49'h0_1357_9BDF_2468, 11'h123, 11'h321, 2'd2, 1'b1, 5'h0C, 1'b1, 19'h2AAAA, 3'd6, 1'b0);
    h2 = mk_hdr(49'h1_0F0F_F0F0_AAAA, 11'h6FF, 11'h700, 2'd1, 1'b0, 5'h13, 1'b0, 19'h15555, 3'd3, 1'b1);
    cnt = bus.hdr_count;
    bus.dout_ready = 1'b1;
    send_hdr(h, ok);
    k = 0; cyc = 0;
    while (k < 4 && cyc < 50) begin
      @(negedge clk);
      if (bus.dout_valid && bus.dout_ready) k++;
      cyc++;
    end
    n_assert++; if (!ok || k != 4) begin n_fail++; $display("FAIL abort_reach_word4 got=%0d exp=4", k); end
    @(negedge clk);
    n_assert++; if (bus.dout !== exp_word(h, 4)) begin n_fail++; $display("FAIL abort_word4 got=%h exp=%h", bus.dout, exp_word(h, 4)); end
    rst = 1'b1;
    @(negedge clk);
    n_assert++; if (bus.dout_valid !== 1'b0) begin n_fail++; $display("FAIL abort_dout_valid got=%b exp=0", bus.dout_valid); end
    n_assert++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
    n_assert++; if (bus.dout !== 16'h0) begin n_fail++; $display("FAIL abort_dout got=%h exp=0000", bus.dout); end
    n_assert++; if (bus.dout_last !== 1'b0) begin n_fail++; $display("FAIL abort_dout_last got=%b exp=0", bus.dout_last); end
    n_assert++; if (bus.hdr_count !== 16'h0) begin n_fail++; $display("FAIL abort_hdr_count got=%h exp=0000 (was %h)", bus.hdr_count, cnt); end
    rst = 1'b0;
    send_hdr(h2, ok);
    collect(0);
    n_assert++; if (!ok || rec_timeout || got_n != NREC) begin n_fail++; $display("FAIL abort_fresh_count got=%0d exp=%0d", got_n, NREC); end
    for (int j = 0; j < NREC; j++) begin
      n_assert++; if (got[j] !== exp_word(h2, j)) begin n_fail++; $display("FAIL abort_fresh_word%0d got=%h exp=%h", j, got[j], exp_word(h2, j)); end
    end
    @(negedge clk);
    n_assert++; if (bus.hdr_count !== 16'd1) begin n_fail++; $display("FAIL abort_fresh_hdr_count got=%0d exp=1", bus.hdr_count); end
  endtask

  initial begin
    rst            = 1'b1;
    bus.hdr_valid  = 1'b0;
    bus.hdr_bundle = '0;
    bus.dout_ready = 1'b1;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_back_to_back();
    test_count_wrap();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
